// File: rtl/seg_decode_pkg.sv
// Shared definitions for the seven-segment readback decoder:
// the segment pattern table, FSM state encoding and a BCD-to-binary helper.
package seg_decode_pkg;

    localparam int SEG_W      = 9;
    localparam int N_PATTERNS = 16;

    // Entry i is the pattern for hex digit i (bit0=a .. bit6=g, bits 8:7 zero).
    localparam logic [N_PATTERNS-1:0][SEG_W-1:0] SEG_TABLE = {
        9'h071, 9'h079, 9'h05e, 9'h039, 9'h07c, 9'h077, 9'h06f, 9'h07f,
        9'h007, 9'h07d, 9'h06d, 9'h066, 9'h04f, 9'h05b, 9'h006, 9'h03f
    };

    typedef enum logic [1:0] {
        ST_ACQ   = 2'd0,
        ST_LOCK  = 2'd1,
        ST_FAULT = 2'd2
    } seg_state_e;

    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens,
                                              input logic [3:0] ones);
        return ({3'b000, tens} * 7'd10) + {3'b000, ones};
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of one 9-bit segment pattern into a digit; legal only
// for an exact table match that decodes to a decimal digit (0..9).
module seg7_pattern_decode
    import seg_decode_pkg::*;
(
    input  logic [SEG_W-1:0] pattern_i,
    output logic             legal_o,
    output logic [3:0]       digit_o
);

    logic matched;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        matched = 1'b0;
        digit_o = 4'd0;
        for (int i = 0; i < N_PATTERNS; i++) begin
            if (pattern_i == SEG_TABLE[i]) begin
                matched = 1'b1;
                digit_o = 4'(i);
            end
        end
    end

    assign legal_o = matched && (digit_o <= 4'd9);

endmodule

// File: rtl/seg_display_decoder.sv
// Reads back a two-digit countdown display: filters unsettled patterns, checks
// countdown order, flags errors. Define SEG_ERR_CNT_EN to build the error counter.
module seg_display_decoder
    import seg_decode_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int RELOAD        = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEG_W-1:0] seg_in_1,
    input  logic [SEG_W-1:0] seg_in_2,
    output logic [3:0]       digit_tens,
    output logic [3:0]       digit_ones,
    output logic [6:0]       value,
    output logic             valid,
    output logic             step,
    output logic             wrap,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam int               CNT_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [6:0]       RELOAD_V   = 7'(RELOAD);

    logic [2*SEG_W-1:0] sample_q;
    logic [2*SEG_W-1:0] sample_d;
    logic [CNT_W-1:0]   stab_q;
    logic [CNT_W-1:0]   stab_d;
    logic               settle;

    logic               tens_legal;
    logic               ones_legal;
    logic [3:0]         new_tens;
    logic [3:0]         new_ones;
    logic               both_legal;
    logic [6:0]         new_value;
    logic [6:0]         value_dec;

    seg_state_e         state_q;
    logic [3:0]         digit_tens_q;
    logic [3:0]         digit_ones_q;
    logic [6:0]         value_q;
    logic               valid_q;
    logic               step_q;
    logic               wrap_q;
    logic               err_q;

    assign sample_d = {seg_in_1, seg_in_2};

    // Compare the live input against the last sample so a settle lands on the
    // same edge that completes the required run of identical samples.
    always_comb begin
        stab_d = '0;
        if (sample_d == sample_q) begin
            stab_d = (stab_q == STABLE_MAX) ? stab_q : stab_q + CNT_ONE;
        end
    end

    assign settle = (stab_d == STABLE_MAX) && (stab_q != STABLE_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sample_q <= '0;
            stab_q   <= '0;
        end else begin
            sample_q <= sample_d;
            stab_q   <= stab_d;
        end
    end

    seg7_pattern_decode u_dec_tens (
        .pattern_i (sample_q[2*SEG_W-1:SEG_W]),
        .legal_o   (tens_legal),
        .digit_o   (new_tens)
    );

    seg7_pattern_decode u_dec_ones (
        .pattern_i (sample_q[SEG_W-1:0]),
        .legal_o   (ones_legal),
        .digit_o   (new_ones)
    );

    assign both_legal = tens_legal && ones_legal;
    assign new_value  = bcd_to_bin(new_tens, new_ones);
    assign value_dec  = value_q - 7'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_ACQ;
            digit_tens_q <= 4'd0;
            digit_ones_q <= 4'd0;
            value_q      <= 7'd0;
            valid_q      <= 1'b0;
            step_q       <= 1'b0;
            wrap_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            if (settle) begin
                case (state_q)
                    ST_ACQ, ST_FAULT: begin
                        if (both_legal) begin
                            digit_tens_q <= new_tens;
                            digit_ones_q <= new_ones;
                            value_q      <= new_value;
                            valid_q      <= 1'b1;
                            state_q      <= ST_LOCK;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    ST_LOCK: begin
                        if (!both_legal) begin
                            err_q   <= 1'b1;
                            valid_q <= 1'b0;
                            state_q <= ST_FAULT;
                        end else if ((value_q != 7'd0) && (new_value == value_dec)) begin
                            step_q       <= 1'b1;
                            digit_tens_q <= new_tens;
                            digit_ones_q <= new_ones;
                            value_q      <= new_value;
                        end else if ((value_q == 7'd0) && (new_value == RELOAD_V)) begin
                            wrap_q       <= 1'b1;
                            digit_tens_q <= new_tens;
                            digit_ones_q <= new_ones;
                            value_q      <= new_value;
                        end else if (new_value != value_q) begin
                            // Out of sequence: flag it but follow the display (resync).
                            err_q        <= 1'b1;
                            digit_tens_q <= new_tens;
                            digit_ones_q <= new_ones;
                            value_q      <= new_value;
                        end
                    end
                    default: begin
                        state_q <= ST_ACQ;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SEG_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt_q <= 8'd0;
        end else if (err_q && (err_cnt_q != 8'hff)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign digit_tens = digit_tens_q;
    assign digit_ones = digit_ones_q;
    assign value      = value_q;
    assign valid      = valid_q;
    assign step       = step_q;
    assign wrap       = wrap_q;
    assign err        = err_q;

endmodule

// File: tb/tb_seg_display_decoder.sv
// Directed self-checking bench for seg_display_decoder (STABLE_CYCLES=4, RELOAD=24);
// expected err_cnt follows SEG_ERR_CNT_EN.
module tb_seg_display_decoder;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] seg_in_1;
    logic [8:0] seg_in_2;
    logic [3:0] digit_tens;
    logic [3:0] digit_ones;
    logic [6:0] value;
    logic       valid;
    logic       step;
    logic       wrap;
    logic       err;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_bad    = 0;
    int n_step   = 0;
    int n_wrap   = 0;
    int n_err    = 0;
    int exp_errs = 0;

    always #5 clk = ~clk;

    seg_display_decoder #(
        .STABLE_CYCLES (STABLE),
        .RELOAD        (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in_1   (seg_in_1),
        .seg_in_2   (seg_in_2),
        .digit_tens (digit_tens),
        .digit_ones (digit_ones),
        .value      (value),
        .valid      (valid),
        .step       (step),
        .wrap       (wrap),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge and counting pulses.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (step === 1'b1) n_step++;
            if (wrap === 1'b1) n_wrap++;
            if (err === 1'b1)  n_err++;
        end
    endtask

    task automatic clear_seen();
        n_step = 0;
        n_wrap = 0;
        n_err  = 0;
    endtask

    task automatic drive(input logic [8:0] tens, input logic [8:0] ones);
        seg_in_1 = tens;
        seg_in_2 = ones;
    endtask

    task automatic settle_pair(input logic [8:0] tens, input logic [8:0] ones);
        drive(tens, ones);
        clear_seen();
        cycles(STABLE + 3);
    endtask

    function automatic int exp_err_cnt();
`ifdef SEG_ERR_CNT_EN
        return (exp_errs > 255) ? 255 : exp_errs;
`else
        return 0;
`endif
    endfunction

    task automatic expect_state(input string tag, input logic exp_valid, input int exp_value,
                                input int exp_steps, input int exp_wraps, input int exp_errs_seen);
        check({tag, ".valid"}, 32'(valid), 32'(exp_valid));
        check({tag, ".value"}, 32'(value), exp_value);
        check({tag, ".tens"},  32'(digit_tens), exp_value / 10);
        check({tag, ".ones"},  32'(digit_ones), exp_value % 10);
        check({tag, ".steps"}, n_step, exp_steps);
        check({tag, ".wraps"}, n_wrap, exp_wraps);
        check({tag, ".errs"},  n_err, exp_errs_seen);
        check({tag, ".err_cnt"}, 32'(err_cnt), exp_err_cnt());
    endtask

    task automatic expect_all_zero(input string tag);
        check({tag, ".valid"}, 32'(valid), 0);
        check({tag, ".value"}, 32'(value), 0);
        check({tag, ".tens"},  32'(digit_tens), 0);
        check({tag, ".ones"},  32'(digit_ones), 0);
        check({tag, ".step"},  32'(step), 0);
        check({tag, ".wrap"},  32'(wrap), 0);
        check({tag, ".err"},   32'(err), 0);
        check({tag, ".err_cnt"}, 32'(err_cnt), 0);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(9'h000, 9'h000);
        cycles(2);
        expect_all_zero("reset");

        // Power-up settle: 24 held from release, accepted on the 5th edge.
        rst = 1'b1;
        drive(9'h05b, 9'h066);
        clear_seen();
        cycles(4);
        check("acq.valid_before", 32'(valid), 0);
        cycles(1);
        check("acq.valid_at5", 32'(valid), 1);
        check("acq.value_at5", 32'(value), 24);
        cycles(3);
        expect_state("acq", 1'b1, 24, 0, 0, 0);

        // 24 -> 23: single step pulse coincident with the value update.
        drive(9'h05b, 9'h04f);
        clear_seen();
        cycles(4);
        check("step.value_before", 32'(value), 24);
        cycles(1);
        check("step.pulse", 32'(step), 1);
        check("step.value", 32'(value), 23);
        check("step.ones", 32'(digit_ones), 3);
        cycles(1);
        check("step.pulse_end", 32'(step), 0);
        cycles(1);
        expect_state("step", 1'b1, 23, 1, 0, 0);

        // Two-cycle glitch (17) then back to 23: ignored.
        drive(9'h006, 9'h07f);
        clear_seen();
        cycles(2);
        drive(9'h05b, 9'h04f);
        cycles(8);
        expect_state("glitch", 1'b1, 23, 0, 0, 0);

        // 23 -> 01 is out of sequence: err and resync.
        settle_pair(9'h03f, 9'h006);
        exp_errs++;
        expect_state("resync01", 1'b1, 1, 0, 0, 1);

        // 01 -> 00 is a legal step down to zero.
        settle_pair(9'h03f, 9'h03f);
        expect_state("step00", 1'b1, 0, 1, 0, 0);

        // 00 -> 24 wraps to RELOAD.
        settle_pair(9'h05b, 9'h066);
        expect_state("wrap", 1'b1, 24, 0, 1, 0);

        // 24 -> 20 and 20 -> 15 are both out of sequence.
        settle_pair(9'h05b, 9'h03f);
        exp_errs++;
        expect_state("resync20", 1'b1, 20, 0, 0, 1);
        settle_pair(9'h006, 9'h06d);
        exp_errs++;
        expect_state("resync15", 1'b1, 15, 0, 0, 1);

        // Blank ones digit: illegal -> FAULT, value held.
        settle_pair(9'h006, 9'h000);
        exp_errs++;
        expect_state("fault", 1'b0, 15, 0, 0, 1);

        // Hex 'A' matches the table but is not a decimal digit: err again in FAULT.
        settle_pair(9'h006, 9'h077);
        exp_errs++;
        expect_state("fault_hex", 1'b0, 15, 0, 0, 1);

        // Recovery to 11: valid again, no step even though 11 != 15-1 context.
        settle_pair(9'h006, 9'h006);
        expect_state("recover", 1'b1, 11, 0, 0, 0);

        // Back in LOCK: 11 -> 10 steps.
        settle_pair(9'h006, 9'h03f);
        expect_state("lock_step", 1'b1, 10, 1, 0, 0);

        // One-edge reset mid-LOCK clears everything.
        rst = 1'b0;
        cycles(1);
        exp_errs = 0;
        expect_all_zero("midreset");
        rst = 1'b1;
        clear_seen();
        cycles(4);
        check("midreset.valid_before", 32'(valid), 0);
        cycles(1);
        check("midreset.valid_at5", 32'(valid), 1);
        cycles(2);
        expect_state("midreset", 1'b1, 10, 0, 0, 0);

        // Fresh ACQ: tens pattern with bit 8 set is illegal, stay in ACQ.
        rst = 1'b0;
        cycles(1);
        rst = 1'b1;
        settle_pair(9'h13f, 9'h03f);
        exp_errs++;
        expect_state("acq_bad", 1'b0, 0, 0, 0, 1);

        // Acquire 00 without wrap/step, then wrap proves LOCK with o=0.
        settle_pair(9'h03f, 9'h03f);
        expect_state("acq00", 1'b1, 0, 0, 0, 0);
        settle_pair(9'h05b, 9'h066);
        expect_state("acq_wrap", 1'b1, 24, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
